// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, coin codes and credit width for the vending controller
package vend_pkg;

    localparam int CREDIT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_FIVE = 2'b01;
    localparam logic [1:0] COIN_TEN  = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    function automatic logic [1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_FIVE: return 2'd1;
            COIN_TEN:  return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// rtl/vend_if.sv - actuator handshakes: dispense motor and change hopper
interface vend_if;
    logic       disp_req;
    logic [1:0] disp_id;
    logic       disp_ack;
    logic       chg_req;
    logic       chg_coin;
    logic       chg_ack;

    modport master (output disp_req, disp_id, chg_req, chg_coin,
                    input  disp_ack, chg_ack);
    modport slave  (input  disp_req, disp_id, chg_req, chg_coin,
                    output disp_ack, chg_ack);
endinterface

// File: rtl/vend_change_issuer.sv
// rtl/vend_change_issuer.sv - pays out a loaded credit amount as tens then a final five
module vend_change_issuer
    import vend_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [CREDIT_W-1:0] i_amount,
    input  logic                i_chg_ack,
    output logic                o_chg_req,
    output logic                o_chg_coin,
    output logic [CREDIT_W-1:0] o_remaining,
    output logic                o_done
);

    logic [CREDIT_W-1:0] r_remaining;
    logic                r_pending;
    logic                r_req;
    logic                w_ack;
    logic [CREDIT_W-1:0] w_step;

    assign w_ack       = r_req & i_chg_ack;
    assign w_step      = (r_remaining >= CREDIT_W'(2)) ? CREDIT_W'(2) : CREDIT_W'(1);
    assign o_chg_req   = r_req;
    assign o_chg_coin  = r_req & (r_remaining >= CREDIT_W'(2));
    assign o_remaining = r_remaining;
    // Last coin: whatever is left fits in one ejection.
    assign o_done      = w_ack & (r_remaining <= CREDIT_W'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_remaining <= '0;
            r_pending   <= 1'b0;
            r_req       <= 1'b0;
        end else if (i_load) begin
            r_remaining <= i_amount;
            r_pending   <= (i_amount != '0);
        end else if (r_pending) begin
            r_req     <= 1'b1;
            r_pending <= 1'b0;
        end else if (w_ack) begin
            r_remaining <= r_remaining - w_step;
            if (o_done) r_req <= 1'b0;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin credit, select/refund/timeout arbitration and actuator sequencing
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int PRICE2     = 5,
    parameter int PRICE3     = 6,
    parameter int MAX_CREDIT = 20,
    parameter int TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          x,
    input  logic                sel_valid,
    input  logic [1:0]          sel,
    input  logic                refund,
    vend_if.master              act,
    output logic                coin_rej,
    output logic                sel_nak,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int TW = $clog2(TIMEOUT + 1);

    vend_state_t         r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [TW-1:0]       r_timer, w_timer_nxt;
    logic                r_disp_req, w_disp_req_nxt;
    logic [1:0]          r_disp_id, w_disp_id_nxt;
    logic                r_coin_rej, w_coin_rej_nxt;
    logic                r_sel_nak, w_sel_nak_nxt;
    logic                w_load, w_claim, w_activity;
    logic [CREDIT_W-1:0] w_price, w_remaining;
    logic [CREDIT_W:0]   w_sum;
    logic                w_chg_req, w_chg_coin, w_chg_done;

    always_comb begin
        case (sel)
            2'd0:    w_price = CREDIT_W'(PRICE0);
            2'd1:    w_price = CREDIT_W'(PRICE1);
            2'd2:    w_price = CREDIT_W'(PRICE2);
            default: w_price = CREDIT_W'(PRICE3);
        endcase
    end

    assign w_sum      = {1'b0, r_credit} + {{(CREDIT_W-1){1'b0}}, coin_value(x)};
    assign w_activity = sel_valid | refund | (x != COIN_NONE);

    always_comb begin
        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_timer_nxt    = '0;
        w_disp_req_nxt = r_disp_req;
        w_disp_id_nxt  = r_disp_id;
        w_coin_rej_nxt = 1'b0;
        w_sel_nak_nxt  = 1'b0;
        w_load         = 1'b0;
        w_claim        = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_CREDIT: begin
                // Select outranks refund, and either one claims the cycle from a coin.
                if (sel_valid) begin
                    if (r_credit >= w_price) begin
                        w_claim        = 1'b1;
                        w_credit_nxt   = r_credit - w_price;
                        w_disp_req_nxt = 1'b1;
                        w_disp_id_nxt  = sel;
                        w_state_nxt    = ST_DISPENSE;
                    end else begin
                        w_sel_nak_nxt = 1'b1;
                    end
                end else if (refund && r_state == ST_CREDIT) begin
                    w_claim      = 1'b1;
                    w_load       = 1'b1;
                    w_credit_nxt = '0;
                    w_state_nxt  = ST_CHANGE;
                end
                if (x == COIN_BAD || (x != COIN_NONE &&
                        (w_claim || w_sum > (CREDIT_W+1)'(MAX_CREDIT)))) begin
                    w_coin_rej_nxt = 1'b1;
                end else if (x != COIN_NONE) begin
                    w_credit_nxt = w_sum[CREDIT_W-1:0];
                    w_state_nxt  = ST_CREDIT;
                end
                if (r_state == ST_CREDIT && !w_activity) begin
                    if (r_timer == TW'(TIMEOUT - 1)) begin
                        w_load       = 1'b1;
                        w_credit_nxt = '0;
                        w_state_nxt  = ST_CHANGE;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
            end
            ST_DISPENSE: begin
                w_sel_nak_nxt  = sel_valid;
                w_coin_rej_nxt = (x != COIN_NONE);
                if (r_disp_req && act.disp_ack) begin
                    w_disp_req_nxt = 1'b0;
                    if (r_credit != '0) begin
                        w_load       = 1'b1;
                        w_credit_nxt = '0;
                        w_state_nxt  = ST_CHANGE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_CHANGE: begin
                w_sel_nak_nxt  = sel_valid;
                w_coin_rej_nxt = (x != COIN_NONE);
                if (w_chg_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_timer    <= '0;
            r_disp_req <= 1'b0;
            r_disp_id  <= 2'd0;
            r_coin_rej <= 1'b0;
            r_sel_nak  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_timer    <= w_timer_nxt;
            r_disp_req <= w_disp_req_nxt;
            r_disp_id  <= w_disp_id_nxt;
            r_coin_rej <= w_coin_rej_nxt;
            r_sel_nak  <= w_sel_nak_nxt;
        end
    end

    // Credit moves into the issuer on entry to CHANGE; it is the visible balance there.
    vend_change_issuer u_change (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_amount    (r_credit),
        .i_chg_ack   (act.chg_ack),
        .o_chg_req   (w_chg_req),
        .o_chg_coin  (w_chg_coin),
        .o_remaining (w_remaining),
        .o_done      (w_chg_done)
    );

    assign act.disp_req = r_disp_req;
    assign act.disp_id  = r_disp_id;
    assign act.chg_req  = w_chg_req;
    assign act.chg_coin = w_chg_coin;
    assign coin_rej     = r_coin_rej;
    assign sel_nak      = r_sel_nak;
    assign busy         = (r_state == ST_DISPENSE) || (r_state == ST_CHANGE);
    assign credit       = (r_state == ST_CHANGE) ? w_remaining : r_credit;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - scoreboard bench for vend_controller with auto-acking actuators
module tb_vend_controller;
    import vend_pkg::*;

    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] x = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       refund = 1'b0;
    logic       coin_rej, sel_nak, busy;
    logic [4:0] credit;

    vend_if act();

    vend_controller #(
        .PRICE0(3), .PRICE1(4), .PRICE2(5), .PRICE3(6),
        .MAX_CREDIT(20), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .sel_valid (sel_valid),
        .sel       (sel),
        .refund    (refund),
        .act       (act),
        .coin_rej  (coin_rej),
        .sel_nak   (sel_nak),
        .busy      (busy),
        .credit    (credit)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] sb_q[$];
    bit         disp_en = 1'b1;
    int         dcnt = 0;
    int         ccnt = 0;

    task automatic check(input string tag, input int obs, input int expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Actuator events: {4'h1, id} for a dispense, {4'h2, coin} for a hopper ejection.
    task automatic sb_check(input string tag, input logic [7:0] obs);
        logic [7:0] expv = 8'hFF;
        if (sb_q.size() > 0) expv = sb_q.pop_front();
        check(tag, int'(obs), int'(expv));
    endtask

    initial begin
        act.disp_ack = 1'b0;
        act.chg_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (act.disp_ack) begin
                act.disp_ack = 1'b0;
            end else if (act.disp_req && disp_en) begin
                dcnt++;
                if (dcnt == 4) begin
                    dcnt = 0;
                    sb_check("disp_event", {4'h1, 2'b00, act.disp_id});
                    act.disp_ack = 1'b1;
                end
            end
            if (act.chg_ack) begin
                act.chg_ack = 1'b0;
            end else if (act.chg_req) begin
                ccnt++;
                if (ccnt == 2) begin
                    ccnt = 0;
                    sb_check("chg_event", {4'h2, 3'b000, act.chg_coin});
                    act.chg_ack = 1'b1;
                end
            end
        end
    end

    task automatic coin(input logic [1:0] c);
        x = c;
        @(negedge clk);
        x = COIN_NONE;
    endtask

    task automatic select(input logic [1:0] id);
        sel_valid = 1'b1;
        sel = id;
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_credit", credit, 0);
        check("rst_disp_req", act.disp_req, 0);
        check("rst_chg_req", act.chg_req, 0);
        check("rst_coin_rej", coin_rej, 0);
        check("rst_sel_nak", sel_nak, 0);
        rst = 1'b1;
        @(negedge clk);

        coin(COIN_BAD);
        check("bad_coin_rej", coin_rej, 1);
        check("bad_coin_credit", credit, 0);
        coin(COIN_FIVE);
        check("c1_credit", credit, 1);
        coin(COIN_TEN);
        check("c1_credit3", credit, 3);
        sb_q.push_back({4'h1, 4'd0});
        select(2'd0);
        check("c1_disp_req", act.disp_req, 1);
        check("c1_disp_id", act.disp_id, 0);
        check("c1_credit_after", credit, 0);
        check("c1_busy", busy, 1);
        wait_idle();
        check("c1_no_chg", act.chg_req, 0);

        coin(COIN_TEN); coin(COIN_TEN); coin(COIN_FIVE);
        check("c2_credit5", credit, 5);
        sb_q.push_back({4'h1, 4'd1});
        sb_q.push_back({4'h2, 4'd0});
        select(2'd1);
        check("c2_disp_id", act.disp_id, 1);
        check("c2_credit_after", credit, 1);
        wait_idle();
        check("c2_credit_end", credit, 0);

        coin(COIN_TEN); coin(COIN_TEN); coin(COIN_FIVE);
        sb_q.push_back({4'h2, 4'd1});
        sb_q.push_back({4'h2, 4'd1});
        sb_q.push_back({4'h2, 4'd0});
        refund = 1'b1;
        @(negedge clk);
        refund = 1'b0;
        check("c3_busy", busy, 1);
        check("c3_credit", credit, 5);
        wait_idle();
        check("c3_credit_end", credit, 0);

        for (int i = 0; i < 9; i++) coin(COIN_TEN);
        coin(COIN_FIVE);
        check("c4_credit19", credit, 19);
        coin(COIN_TEN);
        check("c4_over_rej", coin_rej, 1);
        check("c4_credit_kept", credit, 19);
        coin(COIN_FIVE);
        check("c4_max_ok", coin_rej, 0);
        check("c4_credit20", credit, 20);
        sb_q.push_back({4'h1, 4'd3});
        for (int i = 0; i < 7; i++) sb_q.push_back({4'h2, 4'd1});
        x = COIN_FIVE;
        sel_valid = 1'b1;
        sel = 2'd3;
        @(negedge clk);
        x = COIN_NONE;
        sel_valid = 1'b0;
        check("c4_same_cycle_rej", coin_rej, 1);
        check("c4_credit14", credit, 14);
        check("c4_disp_req", act.disp_req, 1);
        wait_idle();
        check("c4_credit_end", credit, 0);

        coin(COIN_TEN);
        select(2'd3);
        check("c5_sel_nak", sel_nak, 1);
        check("c5_credit2", credit, 2);
        check("c5_not_busy", busy, 0);
        sb_q.push_back({4'h2, 4'd1});
        begin
            int n = 0;
            while (!busy && n < TIMEOUT + 50) begin
                @(negedge clk);
                n++;
            end
            check("c5_timeout_cycles", n, TIMEOUT);
        end
        check("c5_change_credit", credit, 2);
        wait_idle();
        check("c5_credit_end", credit, 0);

        disp_en = 1'b0;
        coin(COIN_TEN); coin(COIN_TEN);
        select(2'd0);
        check("c6_credit1", credit, 1);
        check("c6_disp_req", act.disp_req, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("c6_async_disp_req", act.disp_req, 0);
        check("c6_async_credit", credit, 0);
        check("c6_async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("c6_post_busy", busy, 0);
        check("c6_post_credit", credit, 0);
        check("c6_post_disp_req", act.disp_req, 0);
        disp_en = 1'b1;
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
